// File: rtl/spi_prog_pkg.sv
// Shared types and constants for the SPI frame endpoint / programming passthrough.
package spi_prog_pkg;
  typedef enum logic [1:0] {IDLE, RX, PASS} state_e;
  localparam logic [7:0]  CRC8_POLY     = 8'h07;
  localparam logic [31:0] MSGID_DEFAULT = 32'h74697277;
endpackage

// File: rtl/spi_prog_edge.sv
// 3-FF synchroniser for an async SPI pin with rise/fall detect on stages [2:1].
module spi_prog_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);
  logic [2:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= {3{RST_VAL}};
    else     sync_q <= {sync_q[1:0], d};
  end

  assign rise =  sync_q[1] & ~sync_q[2];
  assign fall = ~sync_q[1] &  sync_q[2];
endmodule

// File: rtl/spi_prog_mux.sv
// SPI slave frame endpoint with multi-target flash passthrough.
// Define SPI_PROG_CRC8_EN to append/check a CRC-8 in the last frame byte (adds crc_err).
module spi_prog_mux
  import spi_prog_pkg::*;
#(
  parameter int          BUFFER_SIZE = 64,
  parameter logic [31:0] MSGID       = MSGID_DEFAULT,
  parameter int          NUM_TARGETS = 2,
  parameter bit          CPOL        = 1'b0,
  parameter bit          CPHA        = 1'b0,
  localparam int         TW          = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mosi,
  output logic                   miso,
  input  logic                   sclk,
  input  logic                   sel,
  input  logic                   prog,
  input  logic [TW-1:0]          prog_target,
  output logic [NUM_TARGETS-1:0] eeprom_mosi,
  input  logic [NUM_TARGETS-1:0] eeprom_miso,
  output logic [NUM_TARGETS-1:0] eeprom_sclk,
  output logic [NUM_TARGETS-1:0] eeprom_sel,
  input  logic [BUFFER_SIZE-1:0] tx_data,
  output logic [BUFFER_SIZE-1:0] rx_data,
  output logic                   sync,
`ifdef SPI_PROG_CRC8_EN
  output logic                   crc_err,
`endif
  output logic                   frame_err
);
  localparam logic [15:0] CNT_FULL = 16'(BUFFER_SIZE);

  state_e                 state_q, state_d;
  logic [TW-1:0]          tgt_q;
  logic [BUFFER_SIZE-1:0] rx_shift, tx_shift, tx_load;
  logic [15:0]            bitcnt;
  logic                   first_shift;
  logic [2:0]             mosi_q;
  logic                   sclk_rise, sclk_fall, sel_rise, sel_fall;
  logic                   sample_edge, shift_edge, hdr_ok, pass_miso;

  spi_prog_edge #(.RST_VAL(CPOL)) u_sclk (
    .clk(clk), .rst(rst), .d(sclk), .rise(sclk_rise), .fall(sclk_fall)
  );
  // sel resets low so a fall is only seen after sel has really been high:
  // a frame interrupted by rst is ignored until the host deselects.
  spi_prog_edge #(.RST_VAL(1'b0)) u_sel (
    .clk(clk), .rst(rst), .d(sel), .rise(sel_rise), .fall(sel_fall)
  );

  always_ff @(posedge clk) begin
    if (rst) mosi_q <= 3'b111;
    else     mosi_q <= {mosi_q[1:0], mosi};
  end

  assign sample_edge = (CPOL == CPHA) ? sclk_rise : sclk_fall;
  assign shift_edge  = (CPOL == CPHA) ? sclk_fall : sclk_rise;
  assign hdr_ok      = (rx_shift[BUFFER_SIZE-1 -: 32] == MSGID);

`ifdef SPI_PROG_CRC8_EN
  function automatic logic [7:0] crc8(input logic [BUFFER_SIZE-9:0] d);
    logic [7:0] c;
    c = 8'h00;
    for (int i = BUFFER_SIZE - 9; i >= 0; i--) begin
      if (c[7] ^ d[i]) c = {c[6:0], 1'b0} ^ CRC8_POLY;
      else             c = {c[6:0], 1'b0};
    end
    return c;
  endfunction

  logic crc_ok;
  assign crc_ok  = (crc8(rx_shift[BUFFER_SIZE-1:8]) == rx_shift[7:0]);
  assign tx_load = {tx_data[BUFFER_SIZE-1:8], crc8(tx_data[BUFFER_SIZE-1:8])};
`else
  assign tx_load = tx_data;
`endif

  always_comb begin
    pass_miso = 1'b1;
    for (int i = 0; i < NUM_TARGETS; i++)
      if (tgt_q == TW'(i)) pass_miso = eeprom_miso[i];
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (sel_fall) state_d = prog ? PASS : RX;
      RX, PASS: if (sel_rise) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      miso        <= 1'b1;
      rx_data     <= '0;
      sync        <= 1'b0;
      frame_err   <= 1'b0;
      tgt_q       <= '0;
      tx_shift    <= '0;
      rx_shift    <= '0;
      bitcnt      <= '0;
      first_shift <= 1'b0;
`ifdef SPI_PROG_CRC8_EN
      crc_err     <= 1'b0;
`endif
    end else begin
      sync      <= 1'b0;
      frame_err <= 1'b0;
`ifdef SPI_PROG_CRC8_EN
      crc_err   <= 1'b0;
`endif
      unique case (state_q)
        IDLE: begin
          miso <= 1'b1;
          if (sel_fall) begin
            tgt_q       <= prog_target;
            tx_shift    <= tx_load;
            bitcnt      <= '0;
            first_shift <= 1'b1;
          end
        end
        RX: begin
          if (sample_edge) begin
            rx_shift <= {rx_shift[BUFFER_SIZE-2:0], mosi_q[2]};
            if (bitcnt != 16'hFFFF) bitcnt <= bitcnt + 16'd1;
          end
          // With CPHA=1 the first leading edge precedes bit 0, so the MSB must stay put.
          if (shift_edge) begin
            first_shift <= 1'b0;
            if (!(CPHA && first_shift)) tx_shift <= {tx_shift[BUFFER_SIZE-2:0], 1'b0};
          end
          miso <= (bitcnt >= CNT_FULL) ? 1'b0 : tx_shift[BUFFER_SIZE-1];
          if (sel_rise) begin
            if (bitcnt != CNT_FULL) frame_err <= 1'b1;
            else if (hdr_ok) begin
`ifdef SPI_PROG_CRC8_EN
              if (crc_ok) begin
                rx_data <= rx_shift;
                sync    <= 1'b1;
              end else begin
                crc_err <= 1'b1;
              end
`else
              rx_data <= rx_shift;
              sync    <= 1'b1;
`endif
            end
          end
        end
        PASS:    miso <= pass_miso;
        default: miso <= 1'b1;
      endcase
    end
  end

  // Passthrough pins: raw host pins registered once; idle as soon as sel rise is seen.
  always_ff @(posedge clk) begin
    for (int t = 0; t < NUM_TARGETS; t++) begin
      if (rst || state_q != PASS || tgt_q != TW'(t) || sel_rise) begin
        eeprom_mosi[t] <= 1'b1;
        eeprom_sclk[t] <= CPOL;
        eeprom_sel[t]  <= 1'b1;
      end else begin
        eeprom_mosi[t] <= mosi;
        eeprom_sclk[t] <= sclk;
        eeprom_sel[t]  <= sel;
      end
    end
  end
endmodule
